keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad scanner with debounce, release tracking, ghost rejection and optional auto-repeat.
//  Drives one row low at a time and samples the columns to build a full-matrix snapshot each scan frame.
//  Validated key events go to the calculator/stopwatch control logic over a valid/ready handshake.
//  Successor to the fixed 4x4 decoder; adds release, repeat and overrun reporting.
// PARAMETERS
//  ROWS           4           number of keypad rows (>=2)
//  COLS           4           number of keypad columns (>=2)
//  CLK_FREQ       50_000_000  clk frequency in Hz
//  SETTLE_CYC     1           cycles a row is driven before its columns are sampled
//  DEBOUNCE_MS    10          press and release debounce time; DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS
//  REPEAT_EN      0           1 = emit repeat events while a key is held
//  REPEAT_DLY_MS  500         hold time before the first repeat event
//  REPEAT_RATE_MS 100         interval between subsequent repeat events
//  (localparam)   CODE_W = $clog2(ROWS*COLS)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  row        out  ROWS    row drive; one-cold (active-low)
//  col        in   COLS    column sense; pulled up, 0 = pressed; asynchronous input
//  key_valid  out  1       key event pending
//  key_ready  in   1       consumer accepts the event when key_valid && key_ready
//  key_code   out  CODE_W  raw index = row*COLS + col_index
//  key_sym    out  4       symbol from keypad_pkg::idx_to_sym (4x4 only; 0 otherwise)
//  key_rpt    out  1       1 = pending event is an auto-repeat
//  key_held   out  1       debounced key currently held
//  overrun    out  1       one-cycle pulse: an event was dropped
// BEHAVIOUR
//  Reset: row all ones. key_valid, key_code, key_sym, key_rpt, key_held, overrun = 0. FSM = IDLE.
//  Scan:
//   - col passes through a 2-flop synchroniser.
//   - Row r is driven for SETTLE_CYC+1 cycles, starting with row 0. col is sampled on the last of those cycles.
//   - After row ROWS-1 is sampled: snapshot (ROWS*COLS bits, 1 = pressed) updates and frame_done pulses for one cycle.
//   - Frame = ROWS*(SETTLE_CYC+1) cycles.
//  FSM, evaluated only on frame_done; the debounce counter advances every clk:
//   - IDLE: exactly one bit set -> latch cand, clear cnt, go to DEBOUNCE.
//     0 bits, or >=2 bits (ghost/chord): stay in IDLE.
//   - DEBOUNCE: snapshot != {cand only} -> IDLE.
//     cnt >= DB_CYC and snapshot == {cand} -> emit press event, set key_held, go to PRESSED.
//   - PRESSED: cand bit clear -> clear cnt, go to RELEASE_DB. Other keys are ignored (2-key lockout).
//     REPEAT_EN: emit a repeat event (key_rpt = 1) after REPEAT_DLY_MS, then every REPEAT_RATE_MS, while held.
//   - RELEASE_DB: cand bit set again -> PRESSED with no new event; the repeat timer restarts.
//     cnt >= DB_CYC with cand clear -> clear key_held, go to IDLE. No release event is emitted.
//  Output register (one deep):
//   - An event loads key_code, key_sym, key_rpt and sets key_valid.
//   - key_valid && key_ready clears key_valid on the next edge.
//   - Event while key_valid && !key_ready: the new event is dropped, overrun pulses, held data is unchanged.
//   - Event in the same cycle as an accept: the new event loads and key_valid stays 1.
//  Latency: press-event key_valid rises on the first frame_done at or after DB_CYC from the first valid frame.
//  rst_n assertion mid-scan or mid-debounce aborts immediately; any pending event is lost.
//  Counter widths: $clog2 of the largest cycle count + 1. Counters saturate and never wrap.
// STRUCTURE
//  keypad_pkg: FSM state enum; KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR, KEY_HASH codes;
//   idx_to_sym() for the layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D;
//   ms_to_cyc() helper.
//  Sub-module keypad_row_scan: synchroniser, row drive, snapshot and frame_done.
//  Top level: FSM, timers and output register.
// TESTING (CLK_FREQ=100_000, DEBOUNCE_MS=1 -> DB_CYC=100, SETTLE_CYC=1, key_ready=1 unless noted)
//  1. Hold row 1 / col 2 low for 500 cycles -> exactly one key_valid with key_code=6, key_sym=KEY_6;
//     key_held=1, then 0 about 100+ cycles after release.
//  2. Bounce idx 0 for 60 cycles (toggle every 8), then hold steady -> one event, code 0,
//     at the first frame_done >= 100 cycles after the last bounce.
//  3. Press idx 0 and idx 5 together -> no event. Release idx 5 -> event code 0 after debounce.
//  4. REPEAT_EN=1, DLY=5 ms, RATE=1 ms; hold idx 15 for 8 ms -> 1 press event + 3 repeats, each key_rpt=1, key_sym=KEY_D.
//  5. key_ready=0; press idx 3, release, press idx 7 -> key_code stays 3, one overrun pulse.
//     Raise key_ready -> single accept.
//  6. Assert rst_n during DEBOUNCE -> all outputs 0 asynchronously. Release rst_n with key still down -> new full debounce before the event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key symbol codes and timing helpers for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE_DB
    } kp_state_e;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, index = row*4 + col.
    function automatic logic [3:0] idx_to_sym(input int idx);
        logic [3:0] sym;
        case (idx)
            0:       sym = KEY_1;
            1:       sym = KEY_2;
            2:       sym = KEY_3;
            3:       sym = KEY_A;
            4:       sym = KEY_4;
            5:       sym = KEY_5;
            6:       sym = KEY_6;
            7:       sym = KEY_B;
            8:       sym = KEY_7;
            9:       sym = KEY_8;
            10:      sym = KEY_9;
            11:      sym = KEY_C;
            12:      sym = KEY_STAR;
            13:      sym = KEY_0;
            14:      sym = KEY_HASH;
            15:      sym = KEY_D;
            default: sym = 4'd0;
        endcase
        return sym;
    endfunction

    function automatic int ms_to_cyc(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row drive, column synchroniser and per-frame snapshot assembly for the keypad matrix.
module keypad_row_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [COLS-1:0]      col_i,
    output logic [ROWS-1:0]      row_o,
    output logic [ROWS*COLS-1:0] snap_o,
    output logic                 frame_done_o
);
    localparam int N     = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);
    localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COLS-1:0]  col_s1_q, col_s2_q;
    logic             run_q;
    logic [SET_W-1:0] set_q, set_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             smp;
    logic             smp_p1_q, smp_p2_q;
    logic [ROW_W-1:0] row_p1_q, row_p2_q;
    logic [N-1:0]     work_q, work_d, snap_q;
    logic             frame_q;
    logic             last_row;

    assign smp      = run_q && (set_q == SET_LAST);
    assign last_row = smp_p2_q && (row_p2_q == ROW_LAST);
    assign row_o        = run_q ? ~(ROWS'(1) << row_q) : '1;
    assign snap_o       = snap_q;
    assign frame_done_o = frame_q;

    // The sample strobe and its row index travel two cycles behind the drive so they
    // line up with the synchronised column value taken on the row's last drive cycle.
    always_comb begin
        set_d  = set_q;
        row_d  = row_q;
        work_d = work_q;
        if (run_q) begin
            if (smp) begin
                set_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                set_d = set_q + SET_W'(1);
            end
        end
        if (smp_p2_q) begin
            work_d[int'(row_p2_q)*COLS +: COLS] = ~col_s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
            run_q    <= 1'b0;
            set_q    <= '0;
            row_q    <= '0;
            smp_p1_q <= 1'b0;
            smp_p2_q <= 1'b0;
            row_p1_q <= '0;
            row_p2_q <= '0;
            work_q   <= '0;
            snap_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            col_s1_q <= col_i;
            col_s2_q <= col_s1_q;
            run_q    <= 1'b1;
            set_q    <= set_d;
            row_q    <= row_d;
            smp_p1_q <= smp;
            row_p1_q <= row_q;
            smp_p2_q <= smp_p1_q;
            row_p2_q <= row_p1_q;
            work_q   <= work_d;
            frame_q  <= last_row;
            if (last_row) begin
                snap_q <= work_d;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: debounce/release FSM, optional auto-repeat and a one-deep event register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CLK_FREQ       = 50_000_000,
    parameter int SETTLE_CYC     = 1,
    parameter int DEBOUNCE_MS    = 10,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DLY_MS  = 500,
    parameter int REPEAT_RATE_MS = 100,
    localparam int CODE_W        = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic [3:0]        key_sym,
    output logic              key_rpt,
    output logic              key_held,
    output logic              overrun
);
    localparam int N        = ROWS * COLS;
    localparam int DB_CYC   = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
    localparam int DLY_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_DLY_MS);
    localparam int RATE_CYC = ms_to_cyc(CLK_FREQ, REPEAT_RATE_MS);
    localparam int RPT_MAX  = (REPEAT_EN != 0) ? ((DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC) : 0;
    localparam int CNT_MAX  = (DB_CYC > RPT_MAX) ? DB_CYC : RPT_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(DLY_CYC);
    localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(RATE_CYC);
    localparam bit IS_4X4 = (ROWS == 4) && (COLS == 4);

    logic [N-1:0]      snap;
    logic              frame_done;
    logic [N-1:0]      cand_mask;
    int                snap_ones;
    logic [CODE_W-1:0] snap_idx;

    kp_state_e         state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, tmr_q, tmr_d;
    logic              first_q, first_d;
    logic              held_q, held_d;
    logic              ev_vld, ev_rpt;

    logic              valid_q, rpt_q, ovr_q;
    logic [CODE_W-1:0] code_q;
    logic [3:0]        sym_q;

    keypad_row_scan #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_scan (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .col_i        (col),
        .row_o        (row),
        .snap_o       (snap),
        .frame_done_o (frame_done)
    );

    always_comb begin
        snap_ones = 0;
        snap_idx  = '0;
        cand_mask = '0;
        cand_mask[cand_q] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (snap[i]) begin
                snap_ones = snap_ones + 1;
                snap_idx  = CODE_W'(i);
            end
        end
    end

    // Timers free-run and saturate; states clear them when a measured interval starts.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        held_d  = held_q;
        first_d = first_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        tmr_d   = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);
        ev_vld  = 1'b0;
        ev_rpt  = 1'b0;
        if (frame_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (snap_ones == 1) begin
                        cand_d  = snap_idx;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (snap != cand_mask) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q >= DB_LIM) begin
                        ev_vld  = 1'b1;
                        held_d  = 1'b1;
                        tmr_d   = '0;
                        first_d = 1'b1;
                        state_d = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!snap[cand_q]) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE_DB;
                    end else if ((REPEAT_EN != 0) && (tmr_q >= (first_q ? DLY_LIM : RATE_LIM))) begin
                        ev_vld  = 1'b1;
                        ev_rpt  = 1'b1;
                        tmr_d   = '0;
                        first_d = 1'b0;
                    end
                end
                ST_RELEASE_DB: begin
                    if (snap[cand_q]) begin
                        tmr_d   = '0;
                        first_d = 1'b1;
                        state_d = ST_PRESSED;
                    end else if (cnt_q >= DB_LIM) begin
                        held_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            first_q <= 1'b1;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            first_q <= first_d;
            held_q  <= held_d;
        end
    end

    // One-deep event holding register; a blocked event is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            sym_q   <= '0;
            rpt_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (ev_vld && valid_q && !key_ready) begin
                ovr_q <= 1'b1;
            end else if (ev_vld) begin
                valid_q <= 1'b1;
                code_q  <= cand_q;
                sym_q   <= IS_4X4 ? idx_to_sym(int'(cand_q)) : 4'd0;
                rpt_q   <= ev_rpt;
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_sym   = sym_q;
    assign key_rpt   = rpt_q;
    assign key_held  = held_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a plain and an auto-repeat instance driven from one modelled 4x4 keypad.
`timescale 1ns/1ps
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] keys;
    logic        key_ready;
    logic [3:0]  row_a, col_a, row_b, col_b;
    logic        key_valid, key_rpt, key_held, overrun;
    logic [3:0]  key_code, key_sym;
    logic        key_valid_r, key_rpt_r, key_held_r, overrun_r;
    logic [3:0]  key_code_r, key_sym_r;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .CLK_FREQ(100_000), .SETTLE_CYC(1), .DEBOUNCE_MS(1),
        .REPEAT_EN(0), .REPEAT_DLY_MS(500), .REPEAT_RATE_MS(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row_a), .col(col_a),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_sym(key_sym), .key_rpt(key_rpt), .key_held(key_held), .overrun(overrun)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .CLK_FREQ(100_000), .SETTLE_CYC(1), .DEBOUNCE_MS(1),
        .REPEAT_EN(1), .REPEAT_DLY_MS(5), .REPEAT_RATE_MS(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .row(row_b), .col(col_b),
        .key_valid(key_valid_r), .key_ready(1'b1), .key_code(key_code_r),
        .key_sym(key_sym_r), .key_rpt(key_rpt_r), .key_held(key_held_r), .overrun(overrun_r)
    );

    // Passive keypad: a pressed key shorts its column to whichever row is driven low.
    always_comb begin
        col_a = '1;
        col_b = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_a[r] && keys[r*4+c]) col_a[c] = 1'b0;
                if (!row_b[r] && keys[r*4+c]) col_b[c] = 1'b0;
            end
        end
    end

    typedef struct {int code; int sym; int rpt; int cyc;} ev_t;
    typedef struct {int idx; int code; int sym;} vec_t;

    ev_t evq[$];
    ev_t evr[$];
    int  cyc = 0;
    int  ovr_cnt = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    bit  rnd_rdy = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (key_valid && key_ready)
                evq.push_back('{int'(key_code), int'(key_sym), int'(key_rpt), cyc});
            if (key_valid_r)
                evr.push_back('{int'(key_code_r), int'(key_sym_r), int'(key_rpt_r), cyc});
            if (overrun) ovr_cnt++;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_held(input string nm, input bit which, input logic v, input int lim);
        int n = 0;
        while (((which ? key_held_r : key_held) !== v) && n < lim) begin
            step(1);
            n++;
        end
        chk(nm, int'(which ? key_held_r : key_held), int'(v));
    endtask

    task automatic wait_ev(input string nm, input bit which, input int lim);
        int n = 0;
        while (((which ? evr.size() : evq.size()) == 0) && n < lim) begin
            step(1);
            n++;
        end
        chk(nm, int'((which ? evr.size() : evq.size()) > 0), 1);
    endtask

    // Reference symbol map derived from the printed keypad layout.
    function automatic int sym_model(input int idx);
        int r = idx / 4;
        int c = idx % 4;
        if (c == 3) return 10 + r;
        if (r < 3) return r * 3 + c + 1;
        return (c == 0) ? 14 : (c == 1) ? 0 : 15;
    endfunction

    vec_t tbl [8];
    int   exp_idx[$];

    initial begin
        int p, t, idx;

        tbl[0] = '{6, 6, KEY_6};
        tbl[1] = '{0, 0, KEY_1};
        tbl[2] = '{3, 3, KEY_A};
        tbl[3] = '{12, 12, KEY_STAR};
        tbl[4] = '{13, 13, KEY_0};
        tbl[5] = '{14, 14, KEY_HASH};
        tbl[6] = '{15, 15, KEY_D};
        tbl[7] = '{9, 9, KEY_8};

        rst_n = 1'b0;
        keys = '0;
        key_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row", int'(row_a), 15);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_sym", int'(key_sym), 0);
        chk("rst_rpt", int'(key_rpt), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(20);

        // Single key presses from the vector table.
        for (int i = 0; i < 8; i++) begin
            evq.delete();
            keys = '0;
            keys[tbl[i].idx] = 1'b1;
            p = cyc;
            step(300);
            chk($sformatf("tbl%0d_held", i), int'(key_held), 1);
            keys = '0;
            t = cyc;
            wait_held($sformatf("tbl%0d_release", i), 1'b0, 1'b0, 300);
            chk_rng($sformatf("tbl%0d_rel_delay", i), cyc - t, 100, 130);
            chk($sformatf("tbl%0d_count", i), evq.size(), 1);
            if (evq.size() > 0) begin
                chk($sformatf("tbl%0d_code", i), evq[0].code, tbl[i].code);
                chk($sformatf("tbl%0d_sym", i), evq[0].sym, tbl[i].sym);
                chk($sformatf("tbl%0d_rpt", i), evq[0].rpt, 0);
                chk_rng($sformatf("tbl%0d_latency", i), evq[0].cyc - p, 100, 130);
            end
            step(10);
        end

        // Contact bounce on idx 0, ending in an 8-cycle open phase before the steady press.
        evq.delete();
        for (int k = 0; k < 8; k++) begin
            keys[0] = (k % 2 == 0);
            step(8);
        end
        keys[0] = 1'b1;
        t = cyc;
        wait_ev("bounce_event", 1'b0, 200);
        step(50);
        chk("bounce_count", evq.size(), 1);
        if (evq.size() > 0) begin
            chk("bounce_code", evq[0].code, 0);
            chk_rng("bounce_latency", evq[0].cyc - t, 100, 130);
        end
        keys = '0;
        wait_held("bounce_release", 1'b0, 1'b0, 300);

        // Chord rejection, then the survivor debounces on its own.
        evq.delete();
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        step(300);
        chk("chord_count", evq.size(), 0);
        chk("chord_held", int'(key_held), 0);
        keys[5] = 1'b0;
        p = cyc;
        wait_ev("chord_event", 1'b0, 200);
        if (evq.size() > 0) begin
            chk("chord_code", evq[0].code, 0);
            chk_rng("chord_latency", evq[0].cyc - p, 100, 130);
        end
        keys = '0;
        wait_held("chord_release", 1'b0, 1'b0, 300);

        // Auto-repeat on the second instance: hold idx 15 for about 8 ms in total.
        wait_held("rpt_idle", 1'b1, 1'b0, 300);
        evr.delete();
        keys[15] = 1'b1;
        wait_ev("rpt_first", 1'b1, 200);
        step(760);
        keys = '0;
        wait_held("rpt_release", 1'b1, 1'b0, 300);
        chk("rpt_count", evr.size(), 4);
        for (int i = 0; i < evr.size() && i < 4; i++) begin
            chk($sformatf("rpt%0d_code", i), evr[i].code, 15);
            chk($sformatf("rpt%0d_sym", i), evr[i].sym, KEY_D);
            chk($sformatf("rpt%0d_flag", i), evr[i].rpt, (i > 0) ? 1 : 0);
        end
        if (evr.size() >= 3) begin
            chk_rng("rpt_delay", evr[1].cyc - evr[0].cyc, 500, 512);
            chk_rng("rpt_rate", evr[2].cyc - evr[1].cyc, 100, 112);
        end

        // Back-pressure: second event is dropped while the first waits.
        evq.delete();
        ovr_cnt = 0;
        key_ready = 1'b0;
        keys[3] = 1'b1;
        step(250);
        keys = '0;
        wait_held("ovr_rel1", 1'b0, 1'b0, 300);
        keys[7] = 1'b1;
        step(250);
        keys = '0;
        wait_held("ovr_rel2", 1'b0, 1'b0, 300);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_valid", int'(key_valid), 1);
        chk("ovr_code", int'(key_code), 3);
        chk("ovr_sym", int'(key_sym), KEY_A);
        key_ready = 1'b1;
        step(5);
        chk("ovr_accepts", evq.size(), 1);
        if (evq.size() > 0) chk("ovr_acc_code", evq[0].code, 3);
        chk("ovr_valid_clr", int'(key_valid), 0);

        // Asynchronous reset in the middle of a debounce.
        evq.delete();
        keys[9] = 1'b1;
        step(40);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_code", int'(key_code), 0);
        chk("arst_sym", int'(key_sym), 0);
        chk("arst_row", int'(row_a), 15);
        chk("arst_valid", int'(key_valid), 0);
        chk("arst_held", int'(key_held), 0);
        step(2);
        rst_n = 1'b1;
        t = cyc;
        wait_ev("arst_event", 1'b0, 250);
        if (evq.size() > 0) begin
            chk("arst_ev_code", evq[0].code, 9);
            chk_rng("arst_latency", evq[0].cyc - t, 100, 135);
        end
        keys = '0;
        wait_held("arst_release", 1'b0, 1'b0, 300);

        // Randomised keys and consumer back-pressure against the reference queue.
        evq.delete();
        exp_idx.delete();
        ovr_cnt = 0;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idx = $urandom_range(0, 15);
            exp_idx.push_back(idx);
            keys = '0;
            keys[idx] = 1'b1;
            step($urandom_range(150, 350));
            keys = '0;
            wait_held($sformatf("rnd%0d_release", i), 1'b0, 1'b0, 300);
            step($urandom_range(0, 30));
        end
        rnd_rdy = 1'b0;
        key_ready = 1'b1;
        step(20);
        chk("rnd_count", evq.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < evq.size(); i++) begin
            chk($sformatf("rnd%0d_code", i), evq[i].code, exp_idx[i]);
            chk($sformatf("rnd%0d_sym", i), evq[i].sym, sym_model(exp_idx[i]));
        end
        chk("rnd_overrun", ovr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
